// File: rtl/fp_pkg.sv
// fp_pkg: shared types, constants and helpers for the minifloat datapath
package fp_pkg;
  localparam int EXP_W_DEF = 3;
  localparam int MAN_W_DEF = 4;
  localparam int BIAS = 2 ** (EXP_W_DEF - 1) - 1;
  localparam int EXP_MAX = 2 ** EXP_W_DEF - 1;
  typedef enum logic [2:0] {ZERO, SUB, NORM, INF, NAN} fp_class_e;
  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
    logic zero;
  } fp_flags_t;
  function automatic logic [31:0] make_qnan(input int ew, input int mw);
    return 32'((((1 << ew) - 1) << mw) | (1 << (mw - 1)));
  endfunction
endpackage

// File: rtl/fp_norm_round.sv
// fp_norm_round: normalise, round-to-nearest-even and pack an aligned significand sum
module fp_norm_round import fp_pkg::*; #(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  localparam int W = 1 + EXP_W + MAN_W,
  localparam int SW = MAN_W + 5
) (
  input  logic             sign,
  input  logic [EXP_W-1:0] exp,
  input  logic [SW-1:0]    sum,
  output logic [W-1:0]     result,
  output fp_flags_t        flags
);
  localparam int NW = SW - 1;
  localparam int XW = EXP_W + $clog2(SW) + 2;
  logic [XW-1:0] lz, ex, sh, e_n, e_r;
  logic [NW-1:0] m;
  logic [MAN_W+1:0] mant;
  logic inexact, hid, ovf, zero_in;
  always_comb begin
    lz = '0;
    for (int i = 0; i < NW; i++) lz = sum[i] ? XW'(NW - 1 - i) : lz;
    ex = XW'(exp);
    // never normalise below the minimum exponent; what is left stays subnormal
    sh = (lz < ex - XW'(1)) ? lz : ex - XW'(1);
    m = sum[SW-1] ? {sum[SW-1:2], |sum[1:0]} : sum[NW-1:0] << sh;
    e_n = sum[SW-1] ? ex + XW'(1) : ex - sh;
    inexact = |m[2:0];
    mant = {1'b0, m[NW-1:3]} + (MAN_W+2)'(m[2] & (m[1] | m[0] | m[3]));
    e_r = mant[MAN_W+1] ? e_n + XW'(1) : e_n;
    hid = |mant[MAN_W+1:MAN_W];
    ovf = e_r >= XW'(2 ** EXP_W - 1);
    zero_in = ~|sum;
    result = zero_in ? {sign, (W-1)'(0)} :
             ovf ? {sign, {EXP_W{1'b1}}, MAN_W'(0)} :
             {sign, hid ? e_r[EXP_W-1:0] : EXP_W'(0), mant[MAN_W-1:0]};
    flags = '{invalid: 1'b0,
              overflow: ~zero_in & ovf,
              underflow: ~zero_in & ~ovf & ~hid & inexact,
              inexact: ~zero_in & (ovf | inexact),
              zero: ~|result[W-2:0]};
  end
endmodule

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: three-stage minifloat add/sub with valid/ready and global stall
module fp_addsub_pipe import fp_pkg::*; #(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         operation,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [4:0]   flags
);
  localparam int NW = MAN_W + 4;
  localparam int SW = MAN_W + 5;
  localparam logic [W-1:0] QNAN = W'(make_qnan(EXP_W, MAN_W));
  logic adv, sa, sbe, swap, nan, spec;
  logic [EXP_W-1:0] ea, eb, e_big, e_sml, f_big, f_sml, d;
  fp_class_e ca, cb;
  logic [MAN_W:0] g_big, g_sml;
  logic [2*NW-1:0] wide;
  logic [NW-1:0] sml_ext;
  logic [W-1:0] sp_res, nr_res;
  logic [SW-1:0] sum;
  fp_flags_t nr_flags;
  logic v1, s1_spec, s1_nan, s1_sign, s1_zsign, s1_sub;
  logic [W-1:0] s1_sp_res;
  logic [EXP_W-1:0] s1_exp;
  logic [NW-1:0] s1_big, s1_sml;
  logic v2, s2_spec, s2_nan, s2_sign;
  logic [W-1:0] s2_sp_res;
  logic [EXP_W-1:0] s2_exp;
  logic [SW-1:0] s2_sum;
  always_comb begin
    adv = !out_valid || out_ready;
    in_ready = adv;
    ea = a[W-2:MAN_W];
    eb = b[W-2:MAN_W];
    sa = a[W-1];
    sbe = b[W-1] ^ operation;
    ca = &ea ? (|a[MAN_W-1:0] ? NAN : INF) : ~|ea ? (|a[MAN_W-1:0] ? SUB : ZERO) : NORM;
    cb = &eb ? (|b[MAN_W-1:0] ? NAN : INF) : ~|eb ? (|b[MAN_W-1:0] ? SUB : ZERO) : NORM;
    nan = ca == NAN || cb == NAN || (ca == INF && cb == INF && sa != sbe);
    spec = nan || ca == INF || cb == INF;
    sp_res = nan ? QNAN : {ca == INF ? sa : sbe, {EXP_W{1'b1}}, MAN_W'(0)};
    swap = b[W-2:0] > a[W-2:0];
    e_big = swap ? eb : ea;
    e_sml = swap ? ea : eb;
    g_big = {|e_big, swap ? b[MAN_W-1:0] : a[MAN_W-1:0]};
    g_sml = {|e_sml, swap ? a[MAN_W-1:0] : b[MAN_W-1:0]};
    f_big = e_big | EXP_W'(~|e_big);
    f_sml = e_sml | EXP_W'(~|e_sml);
    d = f_big - f_sml;
    // align into guard/round/sticky; bits shifted past sticky fold into it
    wide = {g_sml, 3'b000, NW'(0)} >> d;
    sml_ext = int'(d) >= MAN_W + 3 ? {(NW-1)'(0), |g_sml} :
              {wide[2*NW-1:NW+1], wide[NW] | (|wide[NW-1:0])};
    sum = s1_sub ? {1'b0, s1_big} - {1'b0, s1_sml} : {1'b0, s1_big} + {1'b0, s1_sml};
  end
  fp_norm_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_norm (
    .sign(s2_sign),
    .exp(s2_exp),
    .sum(s2_sum),
    .result(nr_res),
    .flags(nr_flags)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      result <= '0;
      flags <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      s1_spec <= spec;
      s1_nan <= nan;
      s1_sp_res <= sp_res;
      s1_sign <= swap ? sbe : sa;
      s1_zsign <= sa & sbe;
      s1_sub <= sa ^ sbe;
      s1_exp <= f_big;
      s1_big <= {g_big, 3'b000};
      s1_sml <= sml_ext;
      v2 <= v1;
      s2_spec <= s1_spec;
      s2_nan <= s1_nan;
      s2_sp_res <= s1_sp_res;
      s2_sign <= ~|sum ? s1_zsign : s1_sign;
      s2_exp <= s1_exp;
      s2_sum <= sum;
      out_valid <= v2;
      if (v2) begin
        result <= s2_spec ? s2_sp_res : nr_res;
        flags <= s2_spec ? {s2_nan, 4'b0000} : nr_flags;
      end
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: scoreboard bench for the pipelined minifloat add/sub
module tb_fp_addsub_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic operation = 1'b0;
  logic in_ready, out_valid;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [7:0] result;
  logic [4:0] flags;
  logic [12:0] q[$];
  logic [12:0] want;
  int errors = 0;
  int checks = 0;
  int nout = 0;
  string tname = "init";

  fp_addsub_pipe dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .operation(operation),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .flags(flags)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      nout++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL %s unexpected_output got res=%b flags=%b want none", tname, result, flags);
      end else begin
        want = q.pop_front();
        if ({result, flags} !== want) begin
          errors++;
          $display("FAIL %s scoreboard got res=%b flags=%b want res=%b flags=%b",
                   tname, result, flags, want[12:5], want[4:0]);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired in %s", tname);
    $fatal(1);
  end

  task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic op,
                       input logic [7:0] er, input logic [4:0] ef);
    int n;
    a = x;
    b = y;
    operation = op;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL %s accept_timeout got in_ready=%b want 1", tname, in_ready);
    end else q.push_back({er, ef});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s drain_timeout got pending=%0d want 0", tname, q.size());
    end
  endtask

  task automatic test_reset;
    tname = "reset";
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    if (result !== 8'h00) begin errors++; $display("FAIL reset result got %b want 0", result); end
    if (flags !== 5'b00000) begin errors++; $display("FAIL reset flags got %b want 0", flags); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic;
    int n;
    tname = "basic";
    out_ready = 1'b1;
    drive(8'h44, 8'h40, 1'b0, 8'h52, 5'b00000);
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL basic latency got %0d cycles want 3", n); end
    drain;
    drive(8'h30, 8'h30, 1'b0, 8'h40, 5'b00000);
    drive(8'h08, 8'h08, 1'b0, 8'h10, 5'b00000);
    drain;
  endtask

  task automatic test_specials;
    tname = "specials";
    drive(8'h70, 8'hF0, 1'b0, 8'h78, 5'b10000);
    drive(8'h6F, 8'h6F, 1'b0, 8'h70, 5'b01010);
    drive(8'h71, 8'h30, 1'b0, 8'h78, 5'b10000);
    drive(8'hF0, 8'h20, 1'b1, 8'hF0, 5'b00000);
    drive(8'h70, 8'h70, 1'b1, 8'h78, 5'b10000);
    drive(8'h80, 8'h80, 1'b0, 8'h80, 5'b00001);
    drain;
  endtask

  task automatic test_subnormal;
    tname = "subnormal";
    drive(8'h21, 8'h22, 1'b1, 8'h82, 5'b00000);
    drive(8'h44, 8'h44, 1'b1, 8'h00, 5'b00001);
    drain;
  endtask

  task automatic test_rounding;
    tname = "rounding";
    drive(8'h50, 8'h01, 1'b0, 8'h50, 5'b00010);
    drive(8'h01, 8'h57, 1'b0, 8'h57, 5'b00010);
    drive(8'h60, 8'h10, 1'b0, 8'h60, 5'b00010);
    drive(8'h61, 8'h10, 1'b0, 8'h62, 5'b00010);
    drive(8'h30, 8'h01, 1'b1, 8'h30, 5'b00010);
    drain;
  endtask

  task automatic test_back_to_back;
    int n0;
    time t0;
    tname = "back_to_back";
    out_ready = 1'b1;
    n0 = nout;
    t0 = $time;
    drive(8'h44, 8'h40, 1'b0, 8'h52, 5'b00000);
    drive(8'h6F, 8'h6F, 1'b0, 8'h70, 5'b01010);
    drive(8'h21, 8'h22, 1'b1, 8'h82, 5'b00000);
    drive(8'h50, 8'h01, 1'b0, 8'h50, 5'b00010);
    drive(8'h61, 8'h10, 1'b0, 8'h62, 5'b00010);
    drive(8'h70, 8'hF0, 1'b0, 8'h78, 5'b10000);
    checks++;
    if ($time - t0 != 60) begin errors++; $display("FAIL back_to_back issue_time got %0t want 60", $time - t0); end
    drain;
    tname = "random_stall";
    fork
      begin
        drive(8'h30, 8'h30, 1'b0, 8'h40, 5'b00000);
        drive(8'h44, 8'h44, 1'b1, 8'h00, 5'b00001);
        drive(8'h60, 8'h10, 1'b0, 8'h60, 5'b00010);
        drive(8'h71, 8'h30, 1'b0, 8'h78, 5'b10000);
        drive(8'h01, 8'h57, 1'b0, 8'h57, 5'b00010);
        drive(8'h80, 8'h80, 1'b0, 8'h80, 5'b00001);
      end
      begin
        repeat (25) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain;
    checks++;
    if (nout - n0 != 12) begin errors++; $display("FAIL back_to_back count got %0d want 12", nout - n0); end
  endtask

  task automatic test_backpressure;
    int n0;
    logic [7:0] r0;
    logic [4:0] f0;
    tname = "backpressure";
    out_ready = 1'b0;
    n0 = nout;
    fork
      begin
        drive(8'h44, 8'h40, 1'b0, 8'h52, 5'b00000);
        drive(8'h6F, 8'h6F, 1'b0, 8'h70, 5'b01010);
        drive(8'h21, 8'h22, 1'b1, 8'h82, 5'b00000);
        drive(8'h50, 8'h01, 1'b0, 8'h50, 5'b00010);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        r0 = result;
        f0 = flags;
        checks += 5;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL backpressure in_ready got %b want 0", in_ready); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL backpressure out_valid got %b want 1", out_valid); end
        if (q.size() != 3) begin errors++; $display("FAIL backpressure in_flight got %0d want 3", q.size()); end
        if (r0 !== 8'h52) begin errors++; $display("FAIL backpressure head_result got %b want 01010010", r0); end
        if (f0 !== 5'b00000) begin errors++; $display("FAIL backpressure head_flags got %b want 00000", f0); end
        repeat (3) @(posedge clk);
        #1;
        checks += 3;
        if (result !== r0) begin errors++; $display("FAIL backpressure stable_result got %b want %b", result, r0); end
        if (flags !== f0) begin errors++; $display("FAIL backpressure stable_flags got %b want %b", flags, f0); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL backpressure hold_in_ready got %b want 0", in_ready); end
        out_ready = 1'b1;
      end
    join
    drain;
    checks++;
    if (nout - n0 != 4) begin errors++; $display("FAIL backpressure count got %0d want 4", nout - n0); end
  endtask

  task automatic test_reset_mid;
    int n;
    int bad;
    tname = "reset_mid";
    out_ready = 1'b1;
    drive(8'h44, 8'h40, 1'b0, 8'h52, 5'b00000);
    drive(8'h6F, 8'h6F, 1'b0, 8'h70, 5'b01010);
    reset = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid out_valid got %b want 0", out_valid); end
    if (result !== 8'h00) begin errors++; $display("FAIL reset_mid result got %b want 0", result); end
    if (flags !== 5'b00000) begin errors++; $display("FAIL reset_mid flags got %b want 0", flags); end
    bad = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_mid stale_valid got %0d cycles want 0", bad); end
    drive(8'h30, 8'h30, 1'b0, 8'h40, 5'b00000);
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL reset_mid latency got %0d cycles want 3", n); end
    drain;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_specials;
    test_subnormal;
    test_rounding;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
